// File: rtl/multu_sequencer_pkg.sv
// Shared function codes, result-mux encodings and FSM state for the multiply sequencer.
// Pure declarations: no latency, no flow control.
package multu_sequencer_pkg;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_SHT = 2'd1;
  localparam logic [1:0] SEL_HI  = 2'd2;
  localparam logic [1:0] SEL_LO  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  function automatic logic [1:0] decode_sel(input logic [5:0] f);
    logic [1:0] sel;
    sel = SEL_ALU;
    case (f)
      FN_SLL:  sel = SEL_SHT;
      FN_MFHI: sel = SEL_HI;
      FN_MFLO: sel = SEL_LO;
      default: sel = SEL_ALU;
    endcase
    return sel;
  endfunction

  // Instructions that touch HI/LO and so must wait for a multiply in flight.
  function automatic logic hilo_dep(input logic [5:0] f);
    return (f == FN_MULTU) || (f == FN_MFHI) || (f == FN_MFLO);
  endfunction

endpackage

// File: rtl/multu_sequencer_if.sv
// Instruction-stage to multiply-sequencer bundle: decoded funct in, strobes and stall out.
// Combinational and registered signals mixed; stall is the only backpressure.
interface multu_sequencer_if;
  logic [5:0] funct;
  logic       valid;
  logic       stall;
  logic       mul_load;
  logic       mul_step;
  logic       hilo_we;
  logic [1:0] mux_sel;
  logic       busy;
  logic       done;
  logic [5:0] count;

  modport master (
    output funct, valid,
    input  stall, mul_load, mul_step, hilo_we, mux_sel, busy, done, count
  );

  modport slave (
    input  funct, valid,
    output stall, mul_load, mul_step, hilo_we, mux_sel, busy, done, count
  );
endinterface

// File: rtl/multu_iter_counter.sv
// Iteration counter for the shift-add multiplier: clr zeroes it, en advances it, last flags WIDTH-1.
// One-cycle registered update; no backpressure.
module multu_iter_counter #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] count,
  output logic       last
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= 6'd0;
    end else if (en) begin
      count <= count + 6'd1;
    end
  end

  assign last = (count == 6'(WIDTH - 1));

endmodule

// File: rtl/multu_sequencer.sv
// Multiply sequencer: IDLE/RUN/WB FSM driving load/step/HiLo-write strobes plus HiLo stall and result-mux decode.
// MULTU occupies WIDTH+2 cycles; HiLo-dependent instructions are held with stall while busy.
module multu_sequencer
  import multu_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  multu_sequencer_if.slave sq
);

  state_t     state;
  state_t     state_nxt;
  logic       busy_q;
  logic       step_q;
  logic       we_q;
  logic       start;
  logic       last;
  logic       stall_c;
  logic [5:0] count;

  assign start = (state == ST_IDLE) && sq.valid && (sq.funct == FN_MULTU);

  multu_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start || (state == ST_WB)),
    .en    ((state == ST_RUN) && !last),
    .count (count),
    .last  (last)
  );

  // Registered strobes are computed from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      step_q <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);
      step_q <= (state_nxt == ST_RUN);
      we_q   <= (state_nxt == ST_WB);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall_c     = !rst && sq.valid && busy_q && hilo_dep(sq.funct);
    sq.stall    = stall_c;
    sq.mul_load = !rst && start;
    sq.mux_sel  = SEL_ALU;
    if (!rst && sq.valid && !stall_c) begin
      sq.mux_sel = decode_sel(sq.funct);
    end
  end

  assign sq.mul_step = step_q;
  assign sq.hilo_we  = we_q;
  assign sq.done     = we_q;
  assign sq.busy     = busy_q;
  assign sq.count    = count;

endmodule

// File: tb/tb_multu_sequencer.sv
// Self-checking bench for multu_sequencer: decode tables in IDLE and RUN, plus multi-cycle sequences.
// HiLo writes are checked against a queue of expected write cycles pushed when MULTU is issued.
module tb_multu_sequencer;
  import multu_sequencer_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [5:0] funct;
    logic       valid;
    logic [1:0] sel;
    logic       stall_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multu_sequencer_if bus();

  multu_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .sq  (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   base   = 0;
  int   exp_q[$];
  int   e_cyc;
  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s rel_cycle=%0d got %0d want %0d", name, cyc - base, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [5:0] f);
    bus.valid = v;
    bus.funct = f;
  endtask

  // Every HiLo write must match the oldest expected write cycle.
  always @(negedge clk) begin
    if (bus.hilo_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("hilo_we_unexpected", 1, 0);
      end else begin
        e_cyc = exp_q.pop_front();
        chk("hilo_we_cycle", cyc, e_cyc);
      end
      chk("done_with_we", int'(bus.done), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int steps;
    int wes;

    vecs[0]  = '{FN_AND,   1'b1, SEL_ALU, 1'b0};
    vecs[1]  = '{FN_OR,    1'b1, SEL_ALU, 1'b0};
    vecs[2]  = '{FN_ADD,   1'b1, SEL_ALU, 1'b0};
    vecs[3]  = '{FN_SUB,   1'b1, SEL_ALU, 1'b0};
    vecs[4]  = '{FN_SLT,   1'b1, SEL_ALU, 1'b0};
    vecs[5]  = '{FN_SLL,   1'b1, SEL_SHT, 1'b0};
    vecs[6]  = '{FN_MFHI,  1'b1, SEL_HI,  1'b1};
    vecs[7]  = '{FN_MFLO,  1'b1, SEL_LO,  1'b1};
    vecs[8]  = '{FN_MULTU, 1'b1, SEL_ALU, 1'b1};
    vecs[9]  = '{6'd7,     1'b1, SEL_ALU, 1'b0};
    vecs[10] = '{6'd63,    1'b1, SEL_ALU, 1'b0};
    vecs[11] = '{FN_MFHI,  1'b0, SEL_ALU, 1'b0};

    // Reset with a MULTU presented: reset must win.
    rst = 1'b1;
    drive(1'b1, FN_MULTU);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_mul_load", int'(bus.mul_load), 0);
    chk("rst_stall",    int'(bus.stall), 0);
    chk("rst_mux_sel",  int'(bus.mux_sel), 0);
    chk("rst_busy",     int'(bus.busy), 0);
    chk("rst_count",    int'(bus.count), 0);
    chk("rst_mul_step", int'(bus.mul_step), 0);
    chk("rst_hilo_we",  int'(bus.hilo_we), 0);
    chk("rst_done",     int'(bus.done), 0);
    next_cycle();
    rst = 1'b0;
    drive(1'b0, FN_SLL);
    next_cycle();

    // Basic MULTU timing.
    base = cyc;
    for (int t = 0; t <= W + 3; t++) begin
      drive(t == 0, FN_MULTU);
      if (t == 0) exp_q.push_back(base + W + 1);
      @(negedge clk);
      chk("basic_mul_load", int'(bus.mul_load), int'(t == 0));
      chk("basic_mul_step", int'(bus.mul_step), int'(t >= 1 && t <= W));
      chk("basic_busy",     int'(bus.busy),     int'(t >= 1 && t <= W + 1));
      chk("basic_count",    int'(bus.count),
          (t >= 1 && t <= W) ? t - 1 : (t == W + 1 ? W - 1 : 0));
      chk("basic_hilo_we",  int'(bus.hilo_we),  int'(t == W + 1));
      chk("basic_done",     int'(bus.done),     int'(t == W + 1));
      next_cycle();
    end

    // Decode table in IDLE (MULTU excluded, it would start a multiply).
    base = cyc;
    foreach (vecs[i]) begin
      if (vecs[i].funct == FN_MULTU && vecs[i].valid) continue;
      drive(vecs[i].valid, vecs[i].funct);
      @(negedge clk);
      chk("idle_stall",    int'(bus.stall), 0);
      chk("idle_mux_sel",  int'(bus.mux_sel), int'(vecs[i].sel));
      chk("idle_mul_load", int'(bus.mul_load), 0);
      chk("idle_busy",     int'(bus.busy), 0);
      next_cycle();
    end
    drive(1'b0, FN_SLL);
    @(negedge clk);
    chk("idle_busy_after", int'(bus.busy), 0);
    next_cycle();

    // Same table applied during RUN.
    base = cyc;
    drive(1'b1, FN_MULTU);
    exp_q.push_back(base + W + 1);
    next_cycle();
    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].funct);
      @(negedge clk);
      chk("run_stall",    int'(bus.stall), int'(vecs[i].stall_busy));
      chk("run_mux_sel",  int'(bus.mux_sel), vecs[i].stall_busy ? 0 : int'(vecs[i].sel));
      chk("run_mul_step", int'(bus.mul_step), 1);
      chk("run_count",    int'(bus.count), i);
      next_cycle();
    end
    drive(1'b0, FN_SLL);
    while (cyc - base <= W + 2) next_cycle();

    // MFLO waits out the multiply; ADD/SLL flow through it.
    base = cyc;
    for (int t = 0; t <= W + 4; t++) begin
      if (t == 0)                    drive(1'b1, FN_MULTU);
      else if (t == 5)               drive(1'b1, FN_ADD);
      else if (t == 6)               drive(1'b1, FN_SLL);
      else if (t >= 10 && t <= W + 2) drive(1'b1, FN_MFLO);
      else                           drive(1'b0, FN_SLL);
      if (t == 0) exp_q.push_back(base + W + 1);
      @(negedge clk);
      if (t == 5) begin
        chk("add_stall",   int'(bus.stall), 0);
        chk("add_mux_sel", int'(bus.mux_sel), 0);
      end
      if (t == 6) begin
        chk("sll_stall",    int'(bus.stall), 0);
        chk("sll_mux_sel",  int'(bus.mux_sel), 1);
        chk("sll_mul_step", int'(bus.mul_step), 1);
        chk("sll_count",    int'(bus.count), 5);
      end
      if (t >= 10 && t <= W + 1) begin
        chk("mflo_stall",   int'(bus.stall), 1);
        chk("mflo_mux_sel", int'(bus.mux_sel), 0);
      end
      if (t == W + 2) begin
        chk("mflo_release_stall", int'(bus.stall), 0);
        chk("mflo_release_sel",   int'(bus.mux_sel), 3);
        chk("mflo_release_load",  int'(bus.mul_load), 0);
        chk("mflo_release_busy",  int'(bus.busy), 0);
      end
      next_cycle();
    end

    // Reset mid-multiply aborts it; a fresh MULTU right after runs to completion.
    base = cyc;
    for (int t = 0; t <= W + 19; t++) begin
      rst = (t == 15);
      drive(t == 0 || t == 16, FN_MULTU);
      if (t == 0)  exp_q.push_back(base + W + 1);
      if (t == 15) exp_q.delete();
      if (t == 16) exp_q.push_back(base + 16 + W + 1);
      @(negedge clk);
      chk("abort_hilo_we", int'(bus.hilo_we), int'(t == 16 + W + 1));
      if (t == 15) chk("abort_rst_load", int'(bus.mul_load), 0);
      if (t == 16) begin
        chk("abort_busy",  int'(bus.busy), 0);
        chk("abort_count", int'(bus.count), 0);
        chk("abort_step",  int'(bus.mul_step), 0);
        chk("abort_load",  int'(bus.mul_load), 1);
      end
      if (t == 17) chk("abort_restart_busy", int'(bus.busy), 1);
      next_cycle();
    end
    rst = 1'b0;

    // Two MULTU held back-to-back.
    base = cyc;
    for (int t = 0; t <= 2 * W + 5; t++) begin
      drive(t <= W + 2, FN_MULTU);
      if (t == 0)     exp_q.push_back(base + W + 1);
      if (t == W + 2) exp_q.push_back(base + 2 * W + 3);
      @(negedge clk);
      chk("b2b_stall",    int'(bus.stall),    int'(t >= 1 && t <= W + 1));
      chk("b2b_mul_load", int'(bus.mul_load), int'(t == 0 || t == W + 2));
      chk("b2b_hilo_we",  int'(bus.hilo_we),  int'(t == W + 1 || t == 2 * W + 3));
      next_cycle();
    end

    // funct toggling between MULTU and AND during RUN never restarts the multiply.
    base  = cyc;
    steps = 0;
    wes   = 0;
    for (int t = 0; t <= W + 8; t++) begin
      if (t == 0)                   drive(1'b1, FN_MULTU);
      else if (t <= W + 1)          drive(1'b1, (t % 2 == 1) ? FN_MULTU : FN_AND);
      else                          drive(1'b0, FN_SLL);
      if (t == 0) exp_q.push_back(base + W + 1);
      @(negedge clk);
      if (bus.mul_step === 1'b1) steps++;
      if (bus.hilo_we === 1'b1) wes++;
      if (t >= 1 && t <= W + 1) chk("toggle_stall", int'(bus.stall), int'(t % 2 == 1));
      next_cycle();
    end
    chk("toggle_step_total", steps, W);
    chk("toggle_we_total", wes, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
